commit_unit: RTL and testbench
==============================

Name: commit_unit

Overview:
- Consumer end of the reorder-buffer commit bus.
- Each cycle it takes at most one committed instruction and retires it:
  - register writeback to the architectural register file;
  - store retirement into a small in-order store queue that drains to data memory over a req/ack handshake;
  - gshare/BTB update for control instructions.
- On a committed misprediction it generates the one-cycle cpuReset/priorCommit recovery pulse back to the reorder buffer and the front end.

Parameters:
WIDTH, 31, data/address MSB index
CONTROL, 5, MSB of controlFlow {isControl,nextState[1:0],writeBTB,takenBranch,reset}
INDEX, 7, MSB of gshare PHT index
ROB, 2, MSB of ROB entry tag
SQ_DEPTH, 4, store queue entries (power of two)

Ports:
clk  in  1  clock, all state on posedge
globalReset  in  1  synchronous active-high reset
validCommit  in  1  commit bus entry valid this cycle
commitInfo  in  4  {regWrite,memWrite,jump,branch}
destCommit  in  WIDTH+1  rd index in [4:0] if regWrite; store address if memWrite
result  in  WIDTH+1  writeback value / store data
controlFlow  in  CONTROL+1  bit0=reset(mispredict), bit1=takenBranch, bit2=writeBTB, [4:3]=nextState, bit5=isControl
targetAddress  in  WIDTH+1  resolved target / redirect PC
oldPC  in  WIDTH+1  instruction PC
previousIndex  in  INDEX+1  PHT index used at fetch
statusSnap  in  WIDTH+1  register status snapshot
commitRob  in  ROB+1  ROB tag of committing entry
memAck  in  1  memory accepted current store
rfWrite  out  1  register file write enable
rfDest  out  5  register index
rfData  out  WIDTH+1  write data
memReq  out  1  store request (queue non-empty)
memAddr  out  WIDTH+1  head store address
memData  out  WIDTH+1  head store data
phtUpdate  out  1  predictor update strobe
phtIndex  out  INDEX+1  index to update
phtTaken  out  1  actual outcome
phtState  out  2  next counter state
btbWrite  out  1  BTB write strobe
btbPC  out  WIDTH+1  BTB tag PC
btbTarget  out  WIDTH+1  BTB target
cpuReset  out  1  recovery pulse
priorCommit  out  1  qualifies cpuReset (asserted with it)
resetPtr  out  ROB+1  ROB tag to rewind write pointer to
redirectPC  out  WIDTH+1  fetch redirect address
restoreStatus  out  WIDTH+1  snapshot to restore register status table
commitStall  out  1  back-pressure: freeze rename/ROB allocation
sqOverflow  out  1  sticky error, store pushed while queue full

Behaviour:
- Reset:
  - globalReset clears all outputs, store queue pointers and count, and sqOverflow to 0.
  - FSM enters RUN.
- Registering: all outputs are registered, giving 1-cycle latency from commit bus to effect.
- FSM:
  - RUN -> RECOVER when validCommit & controlFlow[0]. RECOVER -> RUN unconditionally after one cycle.
  - In RECOVER: cpuReset=priorCommit=1 for exactly that cycle. resetPtr=commitRob latched at the mispredict commit. redirectPC=targetAddress. restoreStatus=statusSnap.
  - validCommit seen in RECOVER is ignored: no rf, store or predictor effect.
- Register writeback: validCommit & regWrite & destCommit[4:0]!=0 -> next cycle rfWrite=1, rfDest=destCommit[4:0], rfData=result. Any other case gives rfWrite=0; x0 writes are suppressed.
- Mispredicted instruction: still retires its own effects (e.g. JALR link write) in the same cycle RECOVER is entered.
- Predictor update: validCommit & controlFlow[5] -> phtUpdate pulse.
  - phtIndex=previousIndex, phtTaken=controlFlow[1], phtState=controlFlow[4:3].
  - btbWrite=controlFlow[2], with btbPC=oldPC, btbTarget=targetAddress.
- Store queue:
  - Circular FIFO of {addr,data}.
  - Push on validCommit & memWrite (RUN only). Pop on memReq & memAck.
  - memReq=(count!=0); memAddr/memData show the head entry. Pointers wrap modulo SQ_DEPTH.
  - Simultaneous push and pop leaves count unchanged, including when full.
  - Push while full with no pop: store dropped, sqOverflow set (sticky until globalReset).
  - Stores already queued survive cpuReset; recovery never flushes the queue.
- Back-pressure: commitStall=(count >= SQ_DEPTH-1), a combinational function of registered count. This gives one entry of slack for a store already on the commit bus.
- globalReset mid-drain: the queue is discarded and memReq drops in the next cycle.

Test Plan:
- Reg write: commit regWrite, destCommit=5, result=0xDEADBEEF -> next cycle rfWrite=1, rfDest=5, rfData=0xDEADBEEF. Same with destCommit=0 -> rfWrite=0.
- Store drain: 3 back-to-back stores (addr 0x100/0x104/0x108), memAck held 0 -> memReq=1, memAddr=0x100, commitStall=1 once count=3. Raise memAck for 3 cycles -> addresses 0x100, 0x104, 0x108 in order, then memReq=0.
- Full + simultaneous: with 4 queued stores, commit a store while memAck=1 -> count stays 4, sqOverflow=0. Commit again with memAck=0 -> sqOverflow=1.
- Mispredict: commit controlFlow=6'b100001, commitRob=3, targetAddress=0x200 -> next cycle cpuReset=priorCommit=1, resetPtr=3, redirectPC=0x200, phtUpdate=1. Cycle after: cpuReset=0. A validCommit during the RECOVER cycle produces no rfWrite.
- Predictor: commit isControl, taken, writeBTB, nextState=2'b11, previousIndex=0x5A, oldPC=0x40 -> phtIndex=0x5A, phtTaken=1, phtState=3, btbWrite=1, btbPC=0x40.
- Reset mid-operation: globalReset with 2 stores queued and FSM in RECOVER -> next cycle all outputs 0, memReq=0, FSM in RUN.

Source files
------------

// File: rtl/commit_unit.sv
// commit_unit: consumer end of the reorder-buffer commit bus.
//
// Retires at most one committed instruction per cycle:
//   - register writeback to the architectural register file (x0 suppressed)
//   - stores pushed into a small in-order queue that drains to memory (req/ack)
//   - gshare PHT / BTB update for control instructions
// A committed misprediction moves the FSM into RECOVER for one cycle. During
// that cycle it drives the cpuReset/priorCommit recovery pulse together with
// the rewind tag, the redirect PC and the status snapshot.
//
// Ports:
//   clk, globalReset             clock, synchronous active-high reset
//   validCommit, commitInfo      commit bus valid, {regWrite,memWrite,jump,branch}
//   destCommit, result           rd index / store address, writeback / store data
//   controlFlow                  {isControl,nextState[1:0],writeBTB,takenBranch,reset}
//   targetAddress, oldPC         resolved target, instruction PC
//   previousIndex                PHT index used at fetch
//   statusSnap, commitRob        status snapshot and ROB tag of the committing entry
//   memAck                       memory accepted the head store
//   rfWrite/rfDest/rfData        register file write port
//   memReq/memAddr/memData       store drain port (head of the queue)
//   pht*/btb*                    predictor update port
//   cpuReset, priorCommit        one-cycle recovery pulse
//   resetPtr, redirectPC         ROB rewind tag, fetch redirect
//   restoreStatus                snapshot for the register status table
//   commitStall                  back-pressure while the queue is nearly full
//   sqOverflow                   sticky: a store was dropped on a full queue
module commit_unit #(
    parameter int WIDTH    = 31,
    parameter int CONTROL  = 5,
    parameter int INDEX    = 7,
    parameter int ROB      = 2,
    parameter int SQ_DEPTH = 4
) (
    input  logic               clk,
    input  logic               globalReset,
    input  logic               validCommit,
    input  logic [3:0]         commitInfo,
    input  logic [WIDTH:0]     destCommit,
    input  logic [WIDTH:0]     result,
    input  logic [CONTROL:0]   controlFlow,
    input  logic [WIDTH:0]     targetAddress,
    input  logic [WIDTH:0]     oldPC,
    input  logic [INDEX:0]     previousIndex,
    input  logic [WIDTH:0]     statusSnap,
    input  logic [ROB:0]       commitRob,
    input  logic               memAck,
    output logic               rfWrite,
    output logic [4:0]         rfDest,
    output logic [WIDTH:0]     rfData,
    output logic               memReq,
    output logic [WIDTH:0]     memAddr,
    output logic [WIDTH:0]     memData,
    output logic               phtUpdate,
    output logic [INDEX:0]     phtIndex,
    output logic               phtTaken,
    output logic [1:0]         phtState,
    output logic               btbWrite,
    output logic [WIDTH:0]     btbPC,
    output logic [WIDTH:0]     btbTarget,
    output logic               cpuReset,
    output logic               priorCommit,
    output logic [ROB:0]       resetPtr,
    output logic [WIDTH:0]     redirectPC,
    output logic [WIDTH:0]     restoreStatus,
    output logic               commitStall,
    output logic               sqOverflow
);

    localparam int PTR_W = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(SQ_DEPTH + 1);

    typedef enum logic {
        RUN,
        RECOVER
    } stateT;

    stateT state;
    stateT nextState;

    logic             accept;
    logic             mispredict;
    logic             push;
    logic             pop;
    logic             full;
    logic             pushAccepted;
    logic [WIDTH:0]   sqAddr [SQ_DEPTH];
    logic [WIDTH:0]   sqData [SQ_DEPTH];
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] count;
    logic             unusedCommitBits;

    // jump/branch only matter upstream; retirement keys off controlFlow instead.
    assign unusedCommitBits = ^commitInfo[1:0];

    // Commits arriving during the RECOVER cycle belong to the squashed path.
    assign accept     = validCommit && (state == RUN);
    assign mispredict = accept && controlFlow[0];

    // A push into a full queue only lands if the head leaves in the same cycle.
    assign push         = accept && commitInfo[2];
    assign pop          = memReq && memAck;
    assign full         = (count == CNT_W'(SQ_DEPTH));
    assign pushAccepted = push && (!full || pop);

    // Head address/data are forced to zero while empty so stale entries never show.
    assign memReq      = (count != '0);
    assign memAddr     = memReq ? sqAddr[headPtr] : '0;
    assign memData     = memReq ? sqData[headPtr] : '0;
    assign commitStall = (count >= CNT_W'(SQ_DEPTH - 1));

    assign cpuReset    = (state == RECOVER);
    assign priorCommit = (state == RECOVER);

    // State register.
    always_ff @(posedge clk) begin
        if (globalReset) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // RECOVER lasts exactly one cycle; a mispredict seen inside it is ignored.
    always_comb begin
        nextState = state;
        case (state)
            RUN:     if (mispredict) nextState = RECOVER;
            RECOVER: nextState = RUN;
            default: nextState = RUN;
        endcase
    end

    // Register writeback and predictor update, registered for one-cycle latency.
    always_ff @(posedge clk) begin
        if (globalReset) begin
            rfWrite   <= 1'b0;
            rfDest    <= '0;
            rfData    <= '0;
            phtUpdate <= 1'b0;
            phtIndex  <= '0;
            phtTaken  <= 1'b0;
            phtState  <= '0;
            btbWrite  <= 1'b0;
            btbPC     <= '0;
            btbTarget <= '0;
        end else begin
            rfWrite   <= accept && commitInfo[3] && (destCommit[4:0] != 5'd0);
            phtUpdate <= accept && controlFlow[5];
            btbWrite  <= accept && controlFlow[5] && controlFlow[2];
            if (accept && commitInfo[3] && (destCommit[4:0] != 5'd0)) begin
                rfDest <= destCommit[4:0];
                rfData <= result;
            end
            if (accept && controlFlow[5]) begin
                phtIndex  <= previousIndex;
                phtTaken  <= controlFlow[1];
                phtState  <= controlFlow[4:3];
                btbPC     <= oldPC;
                btbTarget <= targetAddress;
            end
        end
    end

    // Recovery information is captured at the mispredict commit and held
    // until the next one.
    always_ff @(posedge clk) begin
        if (globalReset) begin
            resetPtr      <= '0;
            redirectPC    <= '0;
            restoreStatus <= '0;
        end else if (mispredict) begin
            resetPtr      <= commitRob;
            redirectPC    <= targetAddress;
            restoreStatus <= statusSnap;
        end
    end

    // Store queue payload; not reset because memAddr/memData are masked when empty.
    always_ff @(posedge clk) begin
        if (!globalReset && pushAccepted) begin
            sqAddr[tailPtr] <= destCommit;
            sqData[tailPtr] <= result;
        end
    end

    // Store queue pointers, occupancy and the sticky overflow flag. Recovery
    // never touches these; only globalReset discards queued stores.
    always_ff @(posedge clk) begin
        if (globalReset) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            count      <= '0;
            sqOverflow <= 1'b0;
        end else begin
            if (pushAccepted) begin
                tailPtr <= tailPtr + PTR_W'(1);
            end
            if (pop) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            if (pushAccepted && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !pushAccepted) begin
                count <= count - CNT_W'(1);
            end
            if (push && full && !pop) begin
                sqOverflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: self-checking bench for commit_unit.
// Table vectors exercise writeback and predictor updates through a scoreboard
// queue; hand-written sequences cover store draining, the full queue,
// misprediction recovery and reset in the middle of operation.
module tb_commit_unit;

    logic        clk = 1'b0;
    logic        globalReset;
    logic        validCommit;
    logic [3:0]  commitInfo;
    logic [31:0] destCommit;
    logic [31:0] result;
    logic [5:0]  controlFlow;
    logic [31:0] targetAddress;
    logic [31:0] oldPC;
    logic [7:0]  previousIndex;
    logic [31:0] statusSnap;
    logic [2:0]  commitRob;
    logic        memAck;
    logic        rfWrite;
    logic [4:0]  rfDest;
    logic [31:0] rfData;
    logic        memReq;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic        phtUpdate;
    logic [7:0]  phtIndex;
    logic        phtTaken;
    logic [1:0]  phtState;
    logic        btbWrite;
    logic [31:0] btbPC;
    logic [31:0] btbTarget;
    logic        cpuReset;
    logic        priorCommit;
    logic [2:0]  resetPtr;
    logic [31:0] redirectPC;
    logic [31:0] restoreStatus;
    logic        commitStall;
    logic        sqOverflow;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        valid;
        logic [3:0]  info;
        logic [31:0] dest;
        logic [31:0] res;
        logic [5:0]  cf;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [7:0]  pidx;
        logic        eRfW;
        logic [4:0]  eRd;
        logic [31:0] eRdat;
        logic        ePht;
        logic [7:0]  eIdx;
        logic        eTaken;
        logic [1:0]  eState;
        logic        eBtb;
        logic [31:0] eBpc;
        logic [31:0] eBtgt;
    } vecT;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } storeT;

    vecT   vecs [8];
    vecT   sbQ [$];
    storeT storeQ [$];

    commit_unit dut (
        .clk(clk),
        .globalReset(globalReset),
        .validCommit(validCommit),
        .commitInfo(commitInfo),
        .destCommit(destCommit),
        .result(result),
        .controlFlow(controlFlow),
        .targetAddress(targetAddress),
        .oldPC(oldPC),
        .previousIndex(previousIndex),
        .statusSnap(statusSnap),
        .commitRob(commitRob),
        .memAck(memAck),
        .rfWrite(rfWrite),
        .rfDest(rfDest),
        .rfData(rfData),
        .memReq(memReq),
        .memAddr(memAddr),
        .memData(memData),
        .phtUpdate(phtUpdate),
        .phtIndex(phtIndex),
        .phtTaken(phtTaken),
        .phtState(phtState),
        .btbWrite(btbWrite),
        .btbPC(btbPC),
        .btbTarget(btbTarget),
        .cpuReset(cpuReset),
        .priorCommit(priorCommit),
        .resetPtr(resetPtr),
        .redirectPC(redirectPC),
        .restoreStatus(restoreStatus),
        .commitStall(commitStall),
        .sqOverflow(sqOverflow)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Hard time limit so the bench always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want normal end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] info, input logic [31:0] dest, input logic [31:0] res,
                                 input logic [5:0] cf, input logic [31:0] tgt, input logic [31:0] pc,
                                 input logic [7:0] pidx, input logic [31:0] snap, input logic [2:0] rob);
        validCommit   = v;
        commitInfo    = info;
        destCommit    = dest;
        result        = res;
        controlFlow   = cf;
        targetAddress = tgt;
        oldPC         = pc;
        previousIndex = pidx;
        statusSnap    = snap;
        commitRob     = rob;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'b0, 32'h0, 32'h0, 6'b0, 32'h0, 32'h0, 8'h0, 32'h0, 3'd0);
    endtask

    task automatic commitStore(input logic [31:0] addr, input logic [31:0] data, input logic expectAccept);
        applyStimulus(1'b1, 4'b0100, addr, data, 6'b0, 32'h0, 32'h0, 8'h0, 32'h0, 3'd0);
        if (expectAccept) storeQ.push_back('{addr, data});
    endtask

    // Holds memAck high and compares each head store against the model queue.
    task automatic drainStores(input string tag);
        int c = 0;
        memAck = 1'b1;
        while (storeQ.size() > 0 && c < 16) begin
            checkOutput({tag, " memReq"}, {31'b0, memReq}, 32'd1);
            checkOutput({tag, " memAddr"}, memAddr, storeQ[0].addr);
            checkOutput({tag, " memData"}, memData, storeQ[0].data);
            tick();
            storeQ.delete(0);
            c++;
        end
        memAck = 1'b0;
        if (storeQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s drain: got %0d stores left, want 0", tag, storeQ.size());
            storeQ.delete();
        end
        checkOutput({tag, " memReq empty"}, {31'b0, memReq}, 32'd0);
    endtask

    initial begin
        vecT e;

        vecs[0] = '{1'b1, 4'b1000, 32'd5,        32'hDEADBEEF, 6'b000000, 32'h0,   32'h0,  8'h00,
                    1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 32'h0,  32'h0};
        vecs[1] = '{1'b1, 4'b1000, 32'd0,        32'h11111111, 6'b000000, 32'h0,   32'h0,  8'h00,
                    1'b0, 5'd0,  32'h0,        1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 32'h0,  32'h0};
        vecs[2] = '{1'b0, 4'b1000, 32'd7,        32'h22222222, 6'b000000, 32'h0,   32'h0,  8'h00,
                    1'b0, 5'd0,  32'h0,        1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 32'h0,  32'h0};
        vecs[3] = '{1'b1, 4'b1010, 32'd1,        32'h00000044, 6'b111110, 32'h80,  32'h40, 8'h5A,
                    1'b1, 5'd1,  32'h44,       1'b1, 8'h5A, 1'b1, 2'd3, 1'b1, 32'h40, 32'h80};
        vecs[4] = '{1'b1, 4'b0001, 32'd0,        32'h0,        6'b101000, 32'h300, 32'h60, 8'h13,
                    1'b0, 5'd0,  32'h0,        1'b1, 8'h13, 1'b0, 2'd1, 1'b0, 32'h0,  32'h0};
        vecs[5] = '{1'b1, 4'b0000, 32'd0,        32'h0,        6'b000110, 32'h90,  32'h70, 8'h22,
                    1'b0, 5'd0,  32'h0,        1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 32'h0,  32'h0};
        vecs[6] = '{1'b1, 4'b1000, 32'hFFFFFFFF, 32'h12345678, 6'b000000, 32'h0,   32'h0,  8'h00,
                    1'b1, 5'd31, 32'h12345678, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 32'h0,  32'h0};
        vecs[7] = '{1'b0, 4'b0000, 32'd0,        32'h0,        6'b111110, 32'hA0,  32'hB0, 8'h33,
                    1'b0, 5'd0,  32'h0,        1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 32'h0,  32'h0};

        // Reset state
        globalReset = 1'b1;
        memAck = 1'b0;
        idle();
        tick();
        tick();
        checkOutput("reset rfWrite", {31'b0, rfWrite}, 32'd0);
        checkOutput("reset memReq", {31'b0, memReq}, 32'd0);
        checkOutput("reset cpuReset", {31'b0, cpuReset}, 32'd0);
        checkOutput("reset priorCommit", {31'b0, priorCommit}, 32'd0);
        checkOutput("reset phtUpdate", {31'b0, phtUpdate}, 32'd0);
        checkOutput("reset btbWrite", {31'b0, btbWrite}, 32'd0);
        checkOutput("reset commitStall", {31'b0, commitStall}, 32'd0);
        checkOutput("reset sqOverflow", {31'b0, sqOverflow}, 32'd0);
        globalReset = 1'b0;

        // Table vectors through the scoreboard
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].info, vecs[i].dest, vecs[i].res, vecs[i].cf,
                          vecs[i].tgt, vecs[i].pc, vecs[i].pidx, 32'h0, 3'd0);
            sbQ.push_back(vecs[i]);
            tick();
            e = sbQ.pop_front();
            checkOutput($sformatf("v%0d rfWrite", i), {31'b0, rfWrite}, {31'b0, e.eRfW});
            if (e.eRfW) begin
                checkOutput($sformatf("v%0d rfDest", i), {27'b0, rfDest}, {27'b0, e.eRd});
                checkOutput($sformatf("v%0d rfData", i), rfData, e.eRdat);
            end
            checkOutput($sformatf("v%0d phtUpdate", i), {31'b0, phtUpdate}, {31'b0, e.ePht});
            if (e.ePht) begin
                checkOutput($sformatf("v%0d phtIndex", i), {24'b0, phtIndex}, {24'b0, e.eIdx});
                checkOutput($sformatf("v%0d phtTaken", i), {31'b0, phtTaken}, {31'b0, e.eTaken});
                checkOutput($sformatf("v%0d phtState", i), {30'b0, phtState}, {30'b0, e.eState});
            end
            checkOutput($sformatf("v%0d btbWrite", i), {31'b0, btbWrite}, {31'b0, e.eBtb});
            if (e.eBtb) begin
                checkOutput($sformatf("v%0d btbPC", i), btbPC, e.eBpc);
                checkOutput($sformatf("v%0d btbTarget", i), btbTarget, e.eBtgt);
            end
            checkOutput($sformatf("v%0d cpuReset", i), {31'b0, cpuReset}, 32'd0);
        end
        idle();
        tick();

        // Store drain: three back-to-back stores with memAck low
        commitStore(32'h100, 32'hA0, 1'b1);
        tick();
        commitStore(32'h104, 32'hB0, 1'b1);
        tick();
        checkOutput("sq2 commitStall", {31'b0, commitStall}, 32'd0);
        commitStore(32'h108, 32'hC0, 1'b1);
        tick();
        idle();
        checkOutput("sq3 memReq", {31'b0, memReq}, 32'd1);
        checkOutput("sq3 memAddr", memAddr, 32'h100);
        checkOutput("sq3 commitStall", {31'b0, commitStall}, 32'd1);
        tick();
        checkOutput("sq3 hold memAddr", memAddr, 32'h100);
        drainStores("drain3");
        checkOutput("drain3 commitStall", {31'b0, commitStall}, 32'd0);

        // Full queue with simultaneous push and pop, then overflow
        commitStore(32'h200, 32'h20, 1'b1);
        tick();
        commitStore(32'h204, 32'h21, 1'b1);
        tick();
        commitStore(32'h208, 32'h22, 1'b1);
        tick();
        commitStore(32'h20C, 32'h23, 1'b1);
        tick();
        checkOutput("full commitStall", {31'b0, commitStall}, 32'd1);
        checkOutput("full memAddr", memAddr, 32'h200);
        commitStore(32'h210, 32'h24, 1'b1);
        memAck = 1'b1;
        storeQ.delete(0);
        tick();
        memAck = 1'b0;
        checkOutput("full pushpop sqOverflow", {31'b0, sqOverflow}, 32'd0);
        checkOutput("full pushpop memAddr", memAddr, 32'h204);
        commitStore(32'h214, 32'h25, 1'b0);
        tick();
        idle();
        checkOutput("overflow sqOverflow", {31'b0, sqOverflow}, 32'd1);
        drainStores("drainFull");
        checkOutput("overflow sticky", {31'b0, sqOverflow}, 32'd1);

        // Mispredict with a store already queued
        commitStore(32'h300, 32'h33, 1'b1);
        tick();
        applyStimulus(1'b1, 4'b1010, 32'd1, 32'h1234, 6'b100001, 32'h200, 32'h50, 8'h07, 32'hCAFE, 3'd3);
        tick();
        checkOutput("mp cpuReset", {31'b0, cpuReset}, 32'd1);
        checkOutput("mp priorCommit", {31'b0, priorCommit}, 32'd1);
        checkOutput("mp resetPtr", {29'b0, resetPtr}, 32'd3);
        checkOutput("mp redirectPC", redirectPC, 32'h200);
        checkOutput("mp restoreStatus", restoreStatus, 32'hCAFE);
        checkOutput("mp phtUpdate", {31'b0, phtUpdate}, 32'd1);
        checkOutput("mp phtIndex", {24'b0, phtIndex}, 32'h07);
        checkOutput("mp btbWrite", {31'b0, btbWrite}, 32'd0);
        checkOutput("mp link rfWrite", {31'b0, rfWrite}, 32'd1);
        checkOutput("mp link rfData", rfData, 32'h1234);
        applyStimulus(1'b1, 4'b1100, 32'd9, 32'h999, 6'b100001, 32'h500, 32'h60, 8'h08, 32'h0, 3'd1);
        tick();
        idle();
        checkOutput("recover cpuReset", {31'b0, cpuReset}, 32'd0);
        checkOutput("recover priorCommit", {31'b0, priorCommit}, 32'd0);
        checkOutput("recover rfWrite", {31'b0, rfWrite}, 32'd0);
        checkOutput("recover phtUpdate", {31'b0, phtUpdate}, 32'd0);
        tick();
        checkOutput("recover no retrigger", {31'b0, cpuReset}, 32'd0);
        drainStores("drainMp");

        // globalReset while in RECOVER with two stores queued
        commitStore(32'h600, 32'h60, 1'b1);
        tick();
        commitStore(32'h604, 32'h61, 1'b1);
        tick();
        applyStimulus(1'b1, 4'b0000, 32'd0, 32'h0, 6'b100001, 32'h700, 32'h70, 8'h01, 32'hBEEF, 3'd2);
        tick();
        checkOutput("rst pre cpuReset", {31'b0, cpuReset}, 32'd1);
        globalReset = 1'b1;
        idle();
        tick();
        globalReset = 1'b0;
        storeQ.delete();
        checkOutput("rst memReq", {31'b0, memReq}, 32'd0);
        checkOutput("rst memAddr", memAddr, 32'h0);
        checkOutput("rst cpuReset", {31'b0, cpuReset}, 32'd0);
        checkOutput("rst priorCommit", {31'b0, priorCommit}, 32'd0);
        checkOutput("rst resetPtr", {29'b0, resetPtr}, 32'd0);
        checkOutput("rst redirectPC", redirectPC, 32'h0);
        checkOutput("rst restoreStatus", restoreStatus, 32'h0);
        checkOutput("rst sqOverflow", {31'b0, sqOverflow}, 32'd0);
        checkOutput("rst commitStall", {31'b0, commitStall}, 32'd0);
        applyStimulus(1'b1, 4'b1000, 32'd3, 32'h77, 6'b100001, 32'h800, 32'h80, 8'h02, 32'h0, 3'd1);
        tick();
        idle();
        checkOutput("post rst rfWrite", {31'b0, rfWrite}, 32'd1);
        checkOutput("post rst cpuReset", {31'b0, cpuReset}, 32'd1);
        checkOutput("post rst resetPtr", {29'b0, resetPtr}, 32'd1);
        checkOutput("post rst redirectPC", redirectPC, 32'h800);
        tick();
        checkOutput("post rst cpuReset end", {31'b0, cpuReset}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
